// File: rtl/udp_pkg.sv
// Shared UDP RX header type, field widths and the
// channel-index width helper used by the port demux.
package udp_pkg;

    localparam int UDP_PORT_WIDTH = 16;
    localparam int AXIS_ID_W      = 8;
    localparam int AXIS_DEST_W    = 8;

    typedef struct packed {
        logic [31:0]               ip_source_ip;
        logic [31:0]               ip_dest_ip;
        logic [UDP_PORT_WIDTH-1:0] source_port;
        logic [UDP_PORT_WIDTH-1:0] dest_port;
        logic [15:0]               length;
        logic [15:0]               checksum;
    } udp_rx_header_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/udp_port_lookup.sv
// Combinational priority match of a UDP destination port
// against a constant port table; lowest matching index wins.
module udp_port_lookup
    import udp_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter logic [NUM_PORTS-1:0][UDP_PORT_WIDTH-1:0] PORT_LIST =
        {16'd4322, 16'd4321},
    localparam int IDX_W = clog2_min1(NUM_PORTS)
) (
    input  logic [UDP_PORT_WIDTH-1:0] dest_port,
    output logic                      hit,
    output logic [IDX_W-1:0]          index
);

    always_comb begin
        hit   = 1'b0;
        index = '0;
        // Descending scan: the lowest matching entry writes last.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (PORT_LIST[i] == dest_port) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_port_demux.sv
// Routes UDP RX header + payload to one of NUM_PORTS sinks by
// destination port; unknown ports are consumed and counted.
module udp_port_demux
    import udp_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter logic [NUM_PORTS-1:0][UDP_PORT_WIDTH-1:0] PORT_LIST =
        {16'd4322, 16'd4321}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_hdr_valid,
    output logic                          in_hdr_ready,
    input  logic [31:0]                   in_ip_source_ip,
    input  logic [31:0]                   in_ip_dest_ip,
    input  logic [15:0]                   in_source_port,
    input  logic [15:0]                   in_dest_port,
    input  logic [15:0]                   in_length,
    input  logic [15:0]                   in_checksum,
    input  logic                          in_tvalid,
    output logic                          in_tready,
    input  logic [7:0]                    in_tdata,
    input  logic                          in_tlast,
    input  logic                          in_tuser,
    input  logic                          in_tkeep,
    input  logic                          in_tstrb,
    input  logic [AXIS_ID_W-1:0]          in_tid,
    input  logic [AXIS_DEST_W-1:0]        in_tdest,
    input  logic                          in_twakeup,
    output logic [NUM_PORTS-1:0]          out_hdr_valid,
    input  logic [NUM_PORTS-1:0]          out_hdr_ready,
    output logic [NUM_PORTS-1:0][31:0]    out_ip_source_ip,
    output logic [NUM_PORTS-1:0][31:0]    out_ip_dest_ip,
    output logic [NUM_PORTS-1:0][15:0]    out_source_port,
    output logic [NUM_PORTS-1:0][15:0]    out_dest_port,
    output logic [NUM_PORTS-1:0][15:0]    out_length,
    output logic [NUM_PORTS-1:0][15:0]    out_checksum,
    output logic [NUM_PORTS-1:0]          out_tvalid,
    input  logic [NUM_PORTS-1:0]          out_tready,
    output logic [NUM_PORTS-1:0][7:0]     out_tdata,
    output logic [NUM_PORTS-1:0]          out_tlast,
    output logic [NUM_PORTS-1:0]          out_tuser,
    output logic [NUM_PORTS-1:0]          out_tkeep,
    output logic [NUM_PORTS-1:0]          out_tstrb,
    output logic [NUM_PORTS-1:0][AXIS_ID_W-1:0]   out_tid,
    output logic [NUM_PORTS-1:0][AXIS_DEST_W-1:0] out_tdest,
    output logic [NUM_PORTS-1:0]          out_twakeup,
    output logic [31:0]                   drop_count
);

    localparam int IDX_W = clog2_min1(NUM_PORTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR_OUT,
        S_PAYLOAD,
        S_DROP
    } state_e;

    state_e               state_q, state_d;
    udp_rx_header_t       hdr_in, hdr_q, hdr_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [NUM_PORTS-1:0] hdr_valid_q, hdr_valid_d;
    logic [31:0]          drop_q, drop_d;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 last_beat;

    assign hdr_in = '{
        ip_source_ip: in_ip_source_ip,
        ip_dest_ip:   in_ip_dest_ip,
        source_port:  in_source_port,
        dest_port:    in_dest_port,
        length:       in_length,
        checksum:     in_checksum
    };

    udp_port_lookup #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_LIST (PORT_LIST)
    ) u_lookup (
        .dest_port (in_dest_port),
        .hit       (hit),
        .index     (hit_idx)
    );

    assign in_hdr_ready  = (state_q == S_IDLE);
    assign out_hdr_valid = hdr_valid_q;
    assign drop_count    = drop_q;
    assign last_beat     = in_tvalid && in_tready && in_tlast;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        sel_d       = sel_q;
        hdr_valid_d = hdr_valid_q;
        drop_d      = drop_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_hdr_valid) begin
                    if (hit) begin
                        hdr_d                = hdr_in;
                        sel_d                = hit_idx;
                        hdr_valid_d          = '0;
                        hdr_valid_d[hit_idx] = 1'b1;
                        state_d              = S_HDR_OUT;
                    end else begin
                        if (drop_q != 32'hFFFF_FFFF) begin
                            drop_d = drop_q + 32'd1;
                        end
                        state_d = S_DROP;
                    end
                end
            end
            S_HDR_OUT: begin
                if (out_hdr_ready[sel_q]) begin
                    hdr_valid_d = '0;
                    state_d     = S_PAYLOAD;
                end
            end
            S_PAYLOAD, S_DROP: begin
                if (last_beat) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload is a zero-latency mux; unselected channels are held at 0.
    always_comb begin
        out_tvalid  = '0;
        out_tdata   = '0;
        out_tlast   = '0;
        out_tuser   = '0;
        out_tkeep   = '0;
        out_tstrb   = '0;
        out_tid     = '0;
        out_tdest   = '0;
        out_twakeup = '0;
        in_tready   = 1'b0;
        if (state_q == S_PAYLOAD) begin
            out_tvalid[sel_q]  = in_tvalid;
            out_tdata[sel_q]   = in_tdata;
            out_tlast[sel_q]   = in_tlast;
            out_tuser[sel_q]   = in_tuser;
            out_tkeep[sel_q]   = in_tkeep;
            out_tstrb[sel_q]   = in_tstrb;
            out_tid[sel_q]     = in_tid;
            out_tdest[sel_q]   = in_tdest;
            out_twakeup[sel_q] = in_twakeup;
            in_tready          = out_tready[sel_q];
        end else if (state_q == S_DROP) begin
            in_tready = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            out_ip_source_ip[i] = hdr_q.ip_source_ip;
            out_ip_dest_ip[i]   = hdr_q.ip_dest_ip;
            out_source_port[i]  = hdr_q.source_port;
            out_dest_port[i]    = hdr_q.dest_port;
            out_length[i]       = hdr_q.length;
            out_checksum[i]     = hdr_q.checksum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            sel_q       <= '0;
            hdr_valid_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            sel_q       <= sel_d;
            hdr_valid_q <= hdr_valid_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_udp_port_demux.sv
// Randomised bench for udp_port_demux against a queue-based
// routing model (port table lookup, per-channel beat stream).
module tb_udp_port_demux;
    import udp_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    udp_rx_header_t in_hdr;
    logic in_hdr_valid, in_hdr_ready;
    logic in_tvalid, in_tready, in_tlast, in_tuser;
    logic in_tkeep, in_tstrb, in_twakeup;
    logic [7:0] in_tdata, in_tid, in_tdest;
    logic [N-1:0] out_hdr_valid, out_hdr_ready;
    logic [N-1:0][31:0] out_ip_source_ip, out_ip_dest_ip;
    logic [N-1:0][15:0] out_source_port, out_dest_port;
    logic [N-1:0][15:0] out_length, out_checksum;
    logic [N-1:0] out_tvalid, out_tready, out_tlast, out_tuser;
    logic [N-1:0] out_tkeep, out_tstrb, out_twakeup;
    logic [N-1:0][7:0] out_tdata, out_tid, out_tdest;
    logic [31:0] drop_count;

    udp_port_demux #(
        .NUM_PORTS (N),
        .PORT_LIST ({16'd4322, 16'd4321})
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_hdr_valid     (in_hdr_valid),
        .in_hdr_ready     (in_hdr_ready),
        .in_ip_source_ip  (in_hdr.ip_source_ip),
        .in_ip_dest_ip    (in_hdr.ip_dest_ip),
        .in_source_port   (in_hdr.source_port),
        .in_dest_port     (in_hdr.dest_port),
        .in_length        (in_hdr.length),
        .in_checksum      (in_hdr.checksum),
        .in_tvalid        (in_tvalid),
        .in_tready        (in_tready),
        .in_tdata         (in_tdata),
        .in_tlast         (in_tlast),
        .in_tuser         (in_tuser),
        .in_tkeep         (in_tkeep),
        .in_tstrb         (in_tstrb),
        .in_tid           (in_tid),
        .in_tdest         (in_tdest),
        .in_twakeup       (in_twakeup),
        .out_hdr_valid    (out_hdr_valid),
        .out_hdr_ready    (out_hdr_ready),
        .out_ip_source_ip (out_ip_source_ip),
        .out_ip_dest_ip   (out_ip_dest_ip),
        .out_source_port  (out_source_port),
        .out_dest_port    (out_dest_port),
        .out_length       (out_length),
        .out_checksum     (out_checksum),
        .out_tvalid       (out_tvalid),
        .out_tready       (out_tready),
        .out_tdata        (out_tdata),
        .out_tlast        (out_tlast),
        .out_tuser        (out_tuser),
        .out_tkeep        (out_tkeep),
        .out_tstrb        (out_tstrb),
        .out_tid          (out_tid),
        .out_tdest        (out_tdest),
        .out_twakeup      (out_twakeup),
        .drop_count       (drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: port table, expected streams, drop total.
    int ref_ports [N] = '{4321, 4322};
    logic [63:0]  exp_b [$];
    logic [63:0]  obs_b [$];
    logic [135:0] exp_h [$];
    logic [135:0] obs_h [$];
    int obs_lat [$];
    int exp_drop = 0;

    int  drop_beats, unstable, multi, rdy_viol, hv_cycles;
    int  cyc = 0;
    int  last_acc = 0;
    bit  tmo, abort, gap_en;
    int  hdr_delay = 0;
    int  rdy_mode = 0;
    int  hv_cnt [N];

    function automatic int ref_route(input logic [15:0] p);
        for (int i = 0; i < N; i++) begin
            if (ref_ports[i] == int'(p)) return i;
        end
        return -1;
    endfunction

    function automatic logic [63:0] enc(
        input int ch, input logic [7:0] d, input logic last,
        input logic user, input logic keep, input logic strb,
        input logic [7:0] id, input logic [7:0] dest,
        input logic wake);
        return {16'(ch), 19'd0, wake, user, last, keep, strb,
                dest, id, d};
    endfunction

    // Sink-side ready generator.
    initial begin
        out_hdr_ready = '0;
        out_tready    = '1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                hv_cnt[i] = out_hdr_valid[i] ? hv_cnt[i] + 1 : 0;
                out_hdr_ready[i] = (hv_cnt[i] > hdr_delay);
                case (rdy_mode)
                    0:       out_tready[i] = 1'b1;
                    1:       out_tready[i] = ~out_tready[i];
                    default: out_tready[i] = ($urandom_range(0, 2) != 0);
                endcase
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    initial begin
        udp_rx_header_t cur;
        udp_rx_header_t hprev [N];
        logic [N-1:0] hv_prev = '0;
        logic [N-1:0] hr_prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_hdr_valid && in_hdr_ready) last_acc = cyc;
            if (|out_hdr_valid && !(|hv_prev))
                obs_lat.push_back(cyc - last_acc);
            if (|out_hdr_valid) hv_cycles++;
            if ($countones(out_tvalid) > 1 ||
                $countones(out_hdr_valid) > 1) multi++;
            if (in_hdr_ready && (|out_hdr_valid || |out_tvalid))
                rdy_viol++;
            if (in_tvalid && in_tready && !(|out_tvalid))
                drop_beats++;
            for (int i = 0; i < N; i++) begin
                cur = '{ip_source_ip: out_ip_source_ip[i],
                        ip_dest_ip:   out_ip_dest_ip[i],
                        source_port:  out_source_port[i],
                        dest_port:    out_dest_port[i],
                        length:       out_length[i],
                        checksum:     out_checksum[i]};
                if (out_hdr_valid[i] && hv_prev[i] && !hr_prev[i] &&
                    cur != hprev[i]) unstable++;
                if (out_hdr_valid[i] && out_hdr_ready[i])
                    obs_h.push_back({8'(i), cur});
                if (out_tvalid[i] && out_tready[i])
                    obs_b.push_back(enc(i, out_tdata[i], out_tlast[i],
                        out_tuser[i], out_tkeep[i], out_tstrb[i],
                        out_tid[i], out_tdest[i], out_twakeup[i]));
                hprev[i] = cur;
            end
            hv_prev = out_hdr_valid;
            hr_prev = out_hdr_ready;
        end
    end

    task automatic clear_obs();
        exp_b.delete(); obs_b.delete();
        exp_h.delete(); obs_h.delete();
        obs_lat.delete();
        drop_beats = 0; unstable = 0; multi = 0;
        rdy_viol = 0; hv_cycles = 0;
        tmo = 1'b0; abort = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Drives one datagram and records what the model expects of it.
    task automatic send_dgram(input logic [15:0] port, input int len,
                              input bit seq);
        udp_rx_header_t h;
        logic [63:0] stim [$];
        logic [63:0] w;
        logic [7:0] d;
        logic last, user;
        int ch, hc, pc;
        h.ip_source_ip = $urandom;
        h.ip_dest_ip   = $urandom;
        h.source_port  = 16'($urandom);
        h.dest_port    = port;
        h.length       = 16'(len + 8);
        h.checksum     = 16'($urandom);
        ch = ref_route(port);
        if (ch < 0) exp_drop++;
        else exp_h.push_back({8'(ch), h});
        for (int k = 0; k < len; k++) begin
            d    = seq ? 8'(k) : 8'($urandom);
            last = (k == len - 1);
            user = last ? 1'($urandom_range(0, 1)) : 1'b0;
            w = enc(0, d, last, user, 1'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom));
            stim.push_back(w);
            if (ch >= 0) exp_b.push_back({16'(ch), w[47:0]});
        end
        fork
            begin
                in_hdr = h;
                in_hdr_valid = 1'b1;
                hc = 0;
                @(negedge clk);
                while (!in_hdr_ready && !abort) begin
                    hc++;
                    if (hc > 2000) begin tmo = 1'b1; abort = 1'b1; end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                in_hdr_valid = 1'b0;
            end
            begin
                foreach (stim[k]) begin
                    if (abort) break;
                    if (gap_en && $urandom_range(0, 3) == 0) begin
                        in_tvalid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    w = stim[k];
                    in_tdata = w[7:0]; in_tid = w[15:8];
                    in_tdest = w[23:16]; in_tstrb = w[24];
                    in_tkeep = w[25]; in_tlast = w[26];
                    in_tuser = w[27]; in_twakeup = w[28];
                    in_tvalid = 1'b1;
                    pc = 0;
                    @(negedge clk);
                    while (!in_tready && !abort) begin
                        pc++;
                        if (pc > 2000) begin tmo = 1'b1; abort = 1'b1; end
                        @(negedge clk);
                    end
                    @(posedge clk);
                    #1;
                end
                in_tvalid = 1'b0;
                in_tlast  = 1'b0;
            end
        join
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_hdr_valid !== '0 || out_tvalid !== '0) begin
            errors++;
            $display("FAIL reset_valid: hdr=%b beat=%b want 0",
                     out_hdr_valid, out_tvalid);
        end
        checks++;
        if (drop_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d want 0", drop_count);
        end
        checks++;
        if (in_hdr_ready !== 1'b1 || in_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: hdr_rdy=%b tready=%b want 1/0",
                     in_hdr_ready, in_tready);
        end
        checks++;
        if (out_ip_source_ip[0] !== 32'd0 || out_length[1] !== 16'd0) begin
            errors++;
            $display("FAIL reset_fields: src=%h len=%h want 0",
                     out_ip_source_ip[0], out_length[1]);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_route_port0();
        int nb, nh;
        clear_obs();
        hdr_delay = 0; rdy_mode = 0; gap_en = 1'b0;
        send_dgram(16'd4321, 10, 1'b1);
        drain();
        nh = (obs_h.size() != exp_h.size()) ? 1 : 0;
        foreach (exp_h[k])
            if (k < obs_h.size() && obs_h[k] !== exp_h[k]) nh++;
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        checks++;
        if (tmo || nh != 0) begin
            errors++;
            $display("FAIL p0_hdr: tmo=%0d hdrs=%0d bad=%0d want 1",
                     tmo, obs_h.size(), nh);
        end
        checks++;
        if (nb != 0 || multi != 0) begin
            errors++;
            $display("FAIL p0_beats: got %0d (%0d bad, multi=%0d) want %0d",
                     obs_b.size(), nb, multi, exp_b.size());
        end
        checks++;
        if (obs_lat.size() != 1 || obs_lat[0] != 1) begin
            errors++;
            $display("FAIL p0_latency: n=%0d lat=%0d want 1",
                     obs_lat.size(), obs_lat.size() ? obs_lat[0] : -1);
        end
        checks++;
        if (drop_count !== 32'(exp_drop)) begin
            errors++;
            $display("FAIL p0_drop: got %0d want %0d", drop_count, exp_drop);
        end
    endtask

    task automatic test_route_port1();
        int nb, nh;
        clear_obs();
        send_dgram(16'd4322, 4, 1'b0);
        drain();
        nh = (obs_h.size() != exp_h.size()) ? 1 : 0;
        foreach (exp_h[k])
            if (k < obs_h.size() && obs_h[k] !== exp_h[k]) nh++;
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        checks++;
        if (tmo || nh != 0) begin
            errors++;
            $display("FAIL p1_hdr_fields: tmo=%0d hdrs=%0d bad=%0d want 1",
                     tmo, obs_h.size(), nh);
        end
        checks++;
        if (nb != 0) begin
            errors++;
            $display("FAIL p1_beats: got %0d (%0d bad) want %0d",
                     obs_b.size(), nb, exp_b.size());
        end
    endtask

    task automatic test_drop();
        int nb;
        clear_obs();
        send_dgram(16'd80, 6, 1'b0);
        drain();
        checks++;
        if (tmo || drop_beats != 6 || obs_b.size() != 0 ||
            obs_h.size() != 0) begin
            errors++;
            $display("FAIL drop_consume: eaten=%0d out=%0d/%0d want 6/0/0",
                     drop_beats, obs_b.size(), obs_h.size());
        end
        checks++;
        if (drop_count !== 32'(exp_drop)) begin
            errors++;
            $display("FAIL drop_count: got %0d want %0d",
                     drop_count, exp_drop);
        end
        clear_obs();
        send_dgram(16'd4321, 5, 1'b0);
        drain();
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        checks++;
        if (tmo || nb != 0 || obs_h.size() != 1) begin
            errors++;
            $display("FAIL drop_recover: beats=%0d bad=%0d hdrs=%0d",
                     obs_b.size(), nb, obs_h.size());
        end
    endtask

    task automatic test_backpressure();
        int nb, nh;
        clear_obs();
        hdr_delay = 5; rdy_mode = 1;
        send_dgram(16'd4321, 9, 1'b0);
        drain();
        hdr_delay = 0; rdy_mode = 0;
        nh = (obs_h.size() != exp_h.size()) ? 1 : 0;
        foreach (exp_h[k])
            if (k < obs_h.size() && obs_h[k] !== exp_h[k]) nh++;
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        checks++;
        if (tmo || nh != 0 || unstable != 0) begin
            errors++;
            $display("FAIL bp_hdr: tmo=%0d bad=%0d unstable=%0d want 0",
                     tmo, nh, unstable);
        end
        checks++;
        if (hv_cycles != 6) begin
            errors++;
            $display("FAIL bp_hdr_hold: valid %0d cycles want 6", hv_cycles);
        end
        checks++;
        if (nb != 0) begin
            errors++;
            $display("FAIL bp_beats: got %0d (%0d bad) want %0d",
                     obs_b.size(), nb, exp_b.size());
        end
        checks++;
        if (rdy_viol != 0) begin
            errors++;
            $display("FAIL bp_in_hdr_ready: %0d busy cycles with ready=1",
                     rdy_viol);
        end
    endtask

    task automatic test_back_to_back();
        int nb, nh;
        clear_obs();
        send_dgram(16'd4321, 3, 1'b0);
        send_dgram(16'd80, 2, 1'b0);
        send_dgram(16'd4322, 3, 1'b0);
        drain();
        nh = (obs_h.size() != exp_h.size()) ? 1 : 0;
        foreach (exp_h[k])
            if (k < obs_h.size() && obs_h[k] !== exp_h[k]) nh++;
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        checks++;
        if (tmo || nh != 0 || nb != 0) begin
            errors++;
            $display("FAIL b2b_order: hdr bad=%0d beat bad=%0d tmo=%0d",
                     nh, nb, tmo);
        end
        checks++;
        if (drop_beats != 2 || drop_count !== 32'(exp_drop)) begin
            errors++;
            $display("FAIL b2b_drop: eaten=%0d cnt=%0d want 2/%0d",
                     drop_beats, drop_count, exp_drop);
        end
    endtask

    task automatic test_random();
        int nb, nh, nl, r;
        logic [15:0] p;
        clear_obs();
        gap_en = 1'b1; rdy_mode = 2;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       p = 16'd4321;
                1:       p = 16'd4322;
                2:       p = 16'd80;
                default: p = 16'($urandom);
            endcase
            hdr_delay = $urandom_range(0, 3);
            send_dgram(p, $urandom_range(1, 12), 1'b0);
        end
        drain();
        gap_en = 1'b0; rdy_mode = 0; hdr_delay = 0;
        nh = (obs_h.size() != exp_h.size()) ? 1 : 0;
        foreach (exp_h[k])
            if (k < obs_h.size() && obs_h[k] !== exp_h[k]) nh++;
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        nl = (obs_lat.size() != exp_h.size()) ? 1 : 0;
        foreach (obs_lat[k]) if (obs_lat[k] != 1) nl++;
        checks++;
        if (tmo || nh != 0 || unstable != 0) begin
            errors++;
            $display("FAIL rnd_hdr: got %0d want %0d bad=%0d unst=%0d",
                     obs_h.size(), exp_h.size(), nh, unstable);
        end
        checks++;
        if (nb != 0 || multi != 0) begin
            errors++;
            $display("FAIL rnd_beats: got %0d want %0d bad=%0d multi=%0d",
                     obs_b.size(), exp_b.size(), nb, multi);
        end
        checks++;
        if (nl != 0 || rdy_viol != 0) begin
            errors++;
            $display("FAIL rnd_timing: lat bad=%0d rdy_viol=%0d",
                     nl, rdy_viol);
        end
        checks++;
        if (drop_count !== 32'(exp_drop)) begin
            errors++;
            $display("FAIL rnd_drop: got %0d want %0d", drop_count, exp_drop);
        end
    endtask

    task automatic test_reset_mid_payload();
        int nb, wc;
        clear_obs();
        fork
            send_dgram(16'd4321, 8, 1'b1);
            begin
                wc = 0;
                do begin
                    @(negedge clk);
                    #2;
                    wc++;
                end while (obs_b.size() < 3 && wc < 500);
                if (wc >= 500) tmo = 1'b1;
                reset_n = 1'b0;
                abort   = 1'b1;
                #1;
                checks++;
                if (tmo || out_tvalid !== '0 || out_hdr_valid !== '0 ||
                    in_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: tv=%b hv=%b rdy=%b tmo=%0d",
                             out_tvalid, out_hdr_valid, in_tready, tmo);
                end
            end
        join
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_hdr_ready !== 1'b1 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_idle: hdr_rdy=%b drop=%0d want 1/0",
                     in_hdr_ready, drop_count);
        end
        @(posedge clk);
        #1;
        clear_obs();
        send_dgram(16'd4322, 3, 1'b0);
        drain();
        nb = (obs_b.size() != exp_b.size()) ? 1 : 0;
        foreach (exp_b[k])
            if (k < obs_b.size() && obs_b[k] !== exp_b[k]) nb++;
        checks++;
        if (tmo || nb != 0 || obs_h.size() != 1) begin
            errors++;
            $display("FAIL rst_mid_recover: beats=%0d bad=%0d hdrs=%0d",
                     obs_b.size(), nb, obs_h.size());
        end
    endtask

    initial begin
        in_hdr       = '0;
        in_hdr_valid = 1'b0;
        in_tvalid    = 1'b0;
        in_tdata     = '0;
        in_tlast     = 1'b0;
        in_tuser     = 1'b0;
        in_tkeep     = 1'b0;
        in_tstrb     = 1'b0;
        in_tid       = '0;
        in_tdest     = '0;
        in_twakeup   = 1'b0;
        gap_en       = 1'b0;
        test_reset();
        test_route_port0();
        test_route_port1();
        test_drop();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_payload();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
